rand_xorshift_buf: RTL and testbench

Parametrised pseudo-random source that replaces the simulation-only `$random` generators with a synthesizable xorshift32 engine. It supports output widths wider than 32 bits, runtime reseeding, and a small prefetch FIFO, so consumers can pop one random word per cycle with a valid/request handshake. It sits beside the other `lib/multi` request/response primitives and is driven by the same single clock.

---
 rtl/rand_xorshift_buf.sv | 123 ++++++++++++
 tb/tb_rand_xorshift_buf.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rand_xorshift_buf.sv
// Synthesizable xorshift32 random word source with multi-chunk assembly, runtime
// reseeding and a first-word fall-through prefetch FIFO.
module rand_xorshift_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter logic [31:0] SEED  = 32'h1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       REQ_WRITE,
  output logic [WIDTH-1:0]           RESP_READ,
  output logic                       RESP_READ_VALID,
  input  logic                       SEED_WRITE,
  input  logic [31:0]                SEED_DATA,
  output logic                       UNDERFLOW,
  output logic [$clog2(DEPTH+1)-1:0] LEVEL
);

  localparam int unsigned NWORDS = (WIDTH + 31) / 32;
  localparam int unsigned LW     = $clog2(DEPTH + 1);
  localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned AW     = NWORDS * 32;

  localparam logic [31:0]   SeedInit  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [CW-1:0] LastChunk = CW'(NWORDS - 1);
  localparam logic [PW-1:0] LastPtr   = PW'(DEPTH - 1);
  localparam logic [LW-1:0] DepthLv   = LW'(DEPTH);

  logic [31:0]      state_q, state_d, next_state;
  logic [CW-1:0]    chunk_q, chunk_d;
  logic [AW-1:0]    asm_q, asm_d, asm_wr;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             underflow_q, underflow_d;
  logic             pop, adv, push, last;

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  always_comb begin
    next_state = xs_step(state_q);
    last       = (chunk_q == LastChunk);
    pop        = REQ_WRITE & (level_q != '0) & ~SEED_WRITE;
    // Advance only if the pushed word is guaranteed a free slot after this edge's pop.
    adv        = ~SEED_WRITE & ((level_q - LW'(pop)) < DepthLv);
    push       = adv & last;

    asm_wr = asm_q;
    for (int k = 0; k < int'(NWORDS); k++) begin
      if (CW'(k) == chunk_q) asm_wr[k*32 +: 32] = next_state;
    end

    state_d     = state_q;
    chunk_d     = chunk_q;
    asm_d       = asm_q;
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    underflow_d = underflow_q;

    if (SEED_WRITE) begin
      state_d     = (SEED_DATA == 32'h0) ? 32'h1 : SEED_DATA;
      chunk_d     = '0;
      asm_d       = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      level_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (REQ_WRITE && (level_q == '0)) underflow_d = 1'b1;
      if (adv) begin
        state_d = next_state;
        asm_d   = asm_wr;
        chunk_d = last ? '0 : chunk_q + CW'(1);
      end
      if (push) begin
        mem_d[wr_ptr_q] = asm_wr[WIDTH-1:0];
        wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= SeedInit;
      chunk_q     <= '0;
      asm_q       <= '0;
      mem_q       <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chunk_q     <= chunk_d;
      asm_q       <= asm_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    RESP_READ_VALID = (level_q != '0);
    RESP_READ       = RESP_READ_VALID ? mem_q[rd_ptr_q] : '0;
    UNDERFLOW       = underflow_q;
    LEVEL           = level_q;
  end

endmodule

// File: tb/tb_rand_xorshift_buf.sv
// Scoreboard bench: three configurations share stimulus; a monitor compares each
// against an integer occupancy model and a precomputed expected-word stream.
module tb_rand_xorshift_buf;

  localparam int          NW   [3] = '{1, 2, 2};
  localparam int          DEP  [3] = '{2, 3, 1};
  localparam int          WID  [3] = '{32, 64, 40};
  localparam logic [31:0] PSEED[3] = '{32'h1, 32'h1, 32'h0};
  localparam int          QLEN = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, sw;
  logic [31:0] sd;

  logic [31:0] rd_a;
  logic [63:0] rd_b;
  logic [39:0] rd_c;
  logic [1:0]  lv_a, lv_b;
  logic [0:0]  lv_c;
  logic        vld_a, vld_b, vld_c, uf_a, uf_b, uf_c;

  logic [127:0] rd  [3];
  logic [7:0]   lv  [3];
  logic [2:0]   vld, ufl;

  assign rd[0] = 128'(rd_a);
  assign rd[1] = 128'(rd_b);
  assign rd[2] = 128'(rd_c);
  assign lv[0] = 8'(lv_a);
  assign lv[1] = 8'(lv_b);
  assign lv[2] = 8'(lv_c);
  assign vld   = {vld_c, vld_b, vld_a};
  assign ufl   = {uf_c, uf_b, uf_a};

  always #5 clk = ~clk;

  rand_xorshift_buf #(.WIDTH(32), .DEPTH(2), .SEED(32'h1)) u_dut_a (
    .CLK(clk), .RESET(rst_n), .REQ_WRITE(req), .RESP_READ(rd_a), .RESP_READ_VALID(vld_a),
    .SEED_WRITE(sw), .SEED_DATA(sd), .UNDERFLOW(uf_a), .LEVEL(lv_a)
  );
  rand_xorshift_buf #(.WIDTH(64), .DEPTH(3), .SEED(32'h1)) u_dut_b (
    .CLK(clk), .RESET(rst_n), .REQ_WRITE(req), .RESP_READ(rd_b), .RESP_READ_VALID(vld_b),
    .SEED_WRITE(sw), .SEED_DATA(sd), .UNDERFLOW(uf_b), .LEVEL(lv_b)
  );
  rand_xorshift_buf #(.WIDTH(40), .DEPTH(1), .SEED(32'h0)) u_dut_c (
    .CLK(clk), .RESET(rst_n), .REQ_WRITE(req), .RESP_READ(rd_c), .RESP_READ_VALID(vld_c),
    .SEED_WRITE(sw), .SEED_DATA(sd), .UNDERFLOW(uf_c), .LEVEL(lv_c)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [127:0] exp_mem [3][QLEN];
  int           m_lvl [3], m_chunk [3], m_head [3], m_since [3];
  bit           m_uf [3];
  logic [31:0]  m_seed [3];
  bit           pop, adv;
  logic [127:0] first_word [3];

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    return y ^ (y << 5);
  endfunction

  task automatic refill(input int d, input logic [31:0] seed);
    logic [31:0]  s;
    logic [127:0] w;
    s = (seed == 32'h0) ? 32'h1 : seed;
    for (int k = 0; k < QLEN; k++) begin
      w = '0;
      for (int j = 0; j < NW[d]; j++) begin
        s = ref_step(s);
        w[32*j +: 32] = s;
      end
      exp_mem[d][k] = w & ((128'h1 << WID[d]) - 128'h1);
    end
  endtask

  task automatic chk(input string name, input int d, input logic [127:0] got,
                     input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, d, $time, got, want);
    end
  endtask

  // Monitor: compare at the falling edge, then predict the effect of the next rising edge.
  initial begin
    first_word[0] = 128'h00042021;
    first_word[1] = 128'h04080601_00042021;
    first_word[2] = 128'h01_00042021;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          chk("rst_level", d, 128'(lv[d]), 128'h0);
          chk("rst_valid", d, 128'(vld[d]), 128'h0);
          chk("rst_data", d, rd[d], 128'h0);
          chk("rst_underflow", d, 128'(ufl[d]), 128'h0);
          m_lvl[d] = 0; m_chunk[d] = 0; m_head[d] = 0; m_since[d] = 0; m_uf[d] = 1'b0;
          m_seed[d] = (PSEED[d] == 32'h0) ? 32'h1 : PSEED[d];
          refill(d, PSEED[d]);
        end else begin
          chk("level", d, 128'(lv[d]), 128'(m_lvl[d]));
          chk("valid", d, 128'(vld[d]), 128'(m_lvl[d] > 0));
          chk("underflow", d, 128'(ufl[d]), 128'(m_uf[d]));
          if (m_lvl[d] > 0) begin
            if (m_head[d] < QLEN) chk("head_data", d, rd[d], exp_mem[d][m_head[d]]);
            else chk("queue_overrun", d, 128'(m_head[d]), 128'(QLEN - 1));
          end
          if (m_seed[d] == 32'h1 && m_since[d] == NW[d] && m_head[d] == 0)
            chk("first_word", d, rd[d], first_word[d]);
          if (d == 0 && m_seed[d] == 32'h1 && m_head[d] == 1 && m_lvl[d] > 0)
            chk("second_word", d, rd[d], 128'h04080601);

          if (sw) begin
            m_lvl[d] = 0; m_chunk[d] = 0; m_head[d] = 0; m_since[d] = 0; m_uf[d] = 1'b0;
            m_seed[d] = (sd == 32'h0) ? 32'h1 : sd;
            refill(d, sd);
          end else begin
            pop = req && (m_lvl[d] > 0);
            if (req && m_lvl[d] == 0) m_uf[d] = 1'b1;
            adv = (m_lvl[d] - int'(pop)) < DEP[d];
            if (pop) m_head[d]++;
            if (adv) begin
              m_chunk[d]++;
              if (m_chunk[d] == NW[d]) begin
                m_chunk[d] = 0;
                m_lvl[d]++;
              end
            end
            if (pop) m_lvl[d]--;
            m_since[d]++;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; sw = 1'b0; sd = 32'h0;
    step(3);
    rst_n = 1'b1;
    step(8);
    req = 1'b1;
    step(20);
    req = 1'b0;

    // Reseed one edge into a 64-bit assembly, with a concurrent request that must be dropped.
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    sw = 1'b1; sd = 32'h0; req = 1'b1;
    step(1);
    sw = 1'b0; req = 1'b0;
    step(6);

    // Request on the very first edge after release, then sticky until reseed.
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1; req = 1'b1;
    step(1);
    req = 1'b0;
    step(5);
    req = 1'b1;
    step(4);
    sw = 1'b1; sd = 32'h1234_5678;
    step(1);
    sw = 1'b0; req = 1'b0;
    step(5);

    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 99) < 60);
      sw  = (i % 100 == 0) || ($urandom_range(0, 49) == 0);
      sd  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      step(1);
    end
    sw = 1'b0; req = 1'b0;

    // Asynchronous reset between edges while every FIFO is full.
    sd = 32'h1;
    sw = 1'b1;
    step(1);
    sw = 1'b0;
    step(10);
    #2 rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(4);
    req = 1'b1;
    step(12);
    req = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
